// File: rtl/lock_pkg.sv
// Shared types and constants for the code-entry lock controller.
// Latency: n/a (package). Backpressure: n/a.
// Ports: none. Provides lock_state_t, DIGIT_W, KEYS and the code-width helper code_w().
package lock_pkg;

   localparam int DIGIT_W = 2;   // bits per entered digit
   localparam int KEYS    = 4;   // keypad buttons, one per digit value

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ENTRY,
      ST_CHECK,
      ST_OPEN,
      ST_PROGRAM,
      ST_LOCKOUT
   } lock_state_t;

   // Width of a packed code holding code_len digits, first digit in the MSBs.
   function automatic int code_w(input int code_len);
      return code_len * DIGIT_W;
   endfunction

endpackage

// File: rtl/key_debouncer.sv
// Tick generator plus tick-sampled debouncer with a one-hot press event output.
// Latency: tick 3 clk_in cycles after a divided_clk rise; key_valid 1 cycle after the settling tick.
// Backpressure: none; key_valid is a single-cycle pulse that must be consumed when seen.
// Ports: clk_in/rst (async, active-high); divided_clk (async slow square wave); raw[W-1:0] bouncy keys;
//        tick (1-cycle pulse per synchronized divided_clk rise); key_valid/key_idx (press of a single key).
module key_debouncer
   import lock_pkg::*;
#(
   parameter int  W     = KEYS,
   localparam int IDX_W = (W > 1) ? $clog2(W) : 1
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             divided_clk,
   input  logic [W-1:0]     raw,
   output logic             tick,
   output logic             key_valid,
   output logic [IDX_W-1:0] key_idx
);

   // dclk_q[1:0] is the synchronizer, dclk_q[2] the edge-detect register.
   logic [2:0]       dclk_q,      dclk_d;
   logic             tick_q,      tick_d;
   logic [W-1:0]     sync1_q,     sync1_d;
   logic [W-1:0]     sync2_q,     sync2_d;
   logic [W-1:0]     samp_q,      samp_d;
   logic [W-1:0]     deb_q,       deb_d;
   logic             key_valid_q, key_valid_d;
   logic [IDX_W-1:0] key_idx_q,   key_idx_d;
   logic             one_hot;

   always_comb begin
      dclk_d  = {dclk_q[1:0], divided_clk};
      tick_d  = dclk_q[1] & ~dclk_q[2];
      sync1_d = raw;
      sync2_d = sync1_q;
      samp_d  = samp_q;
      deb_d   = deb_q;
      // Accept a new level only when two consecutive tick samples agree.
      if (tick_q) begin
         samp_d = sync2_q;
         if (sync2_q == samp_q) begin
            deb_d = sync2_q;
         end
      end
      one_hot     = (deb_d != '0) && ((deb_d & (deb_d - W'(1))) == '0);
      // Only a clean 0 -> single-key transition is a press; chords and
      // chord-to-single transitions wait for a full release first.
      key_valid_d = (deb_q == '0) && one_hot;
      key_idx_d   = '0;
      for (int i = 0; i < W; i++) begin
         if (deb_d[i]) begin
            key_idx_d = IDX_W'(i);
         end
      end
   end

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         dclk_q      <= '0;
         tick_q      <= 1'b0;
         sync1_q     <= '0;
         sync2_q     <= '0;
         samp_q      <= '0;
         deb_q       <= '0;
         key_valid_q <= 1'b0;
         key_idx_q   <= '0;
      end else begin
         dclk_q      <= dclk_d;
         tick_q      <= tick_d;
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         samp_q      <= samp_d;
         deb_q       <= deb_d;
         key_valid_q <= key_valid_d;
         key_idx_q   <= key_idx_d;
      end
   end

   assign tick      = tick_q;
   assign key_valid = key_valid_q;
   assign key_idx   = key_idx_q;

endmodule

// File: rtl/lock_controller.sv
// Code-entry lock: debounced keypad entry, code compare, unlock/reprogram, failed-attempt lockout.
// Latency: key event to digit_cnt 1 cycle; last digit -> CHECK 1 cycle -> outputs 1 cycle; all outputs registered.
// Backpressure: none; key events outside IDLE/ENTRY/PROGRAM are dropped.
// Ports: clk_in/rst (async, active-high); divided_clk (async tick source); btn[3:0] raw keys; set_code raw switch;
//        unlocked, lockout, error, digit_cnt[2:0], fail_cnt[1:0] status outputs.
module lock_controller
   import lock_pkg::*;
#(
   parameter int                          CODE_LEN      = 4,
   parameter logic [code_w(CODE_LEN)-1:0] DEFAULT_CODE  = 8'b00_01_10_11,
   parameter int                          MAX_FAILS     = 3,
   parameter int                          UNLOCK_TICKS  = 25,
   parameter int                          LOCKOUT_TICKS = 100,
   parameter int                          ENTRY_TIMEOUT = 20
) (
   input  logic       clk_in,
   input  logic       rst,
   input  logic       divided_clk,
   input  logic [3:0] btn,
   input  logic       set_code,
   output logic       unlocked,
   output logic       lockout,
   output logic       error,
   output logic [2:0] digit_cnt,
   output logic [1:0] fail_cnt
);

   localparam int CODE_W = code_w(CODE_LEN);
   localparam int MAX_T  = (UNLOCK_TICKS > LOCKOUT_TICKS)
                         ? ((UNLOCK_TICKS > ENTRY_TIMEOUT) ? UNLOCK_TICKS : ENTRY_TIMEOUT)
                         : ((LOCKOUT_TICKS > ENTRY_TIMEOUT) ? LOCKOUT_TICKS : ENTRY_TIMEOUT);
   localparam int TICK_W = $clog2(MAX_T) + 1;

   logic               btn_tick, set_tick, tick;
   logic               key_vld, set_vld, set_rise;
   logic [DIGIT_W-1:0] key_idx;
   logic [0:0]         set_idx;

   key_debouncer #(.W(KEYS)) u_btn_deb (
      .clk_in      (clk_in),
      .rst         (rst),
      .divided_clk (divided_clk),
      .raw         (btn),
      .tick        (btn_tick),
      .key_valid   (key_vld),
      .key_idx     (key_idx)
   );

   key_debouncer #(.W(1)) u_set_deb (
      .clk_in      (clk_in),
      .rst         (rst),
      .divided_clk (divided_clk),
      .raw         (set_code),
      .tick        (set_tick),
      .key_valid   (set_vld),
      .key_idx     (set_idx)
   );

   // Both instances see the same divided_clk, so their ticks coincide.
   assign tick     = btn_tick | set_tick;
   // A 1-bit "press" is a debounced rising edge; its only key index is 0.
   assign set_rise = set_vld & ~set_idx[0];

   lock_state_t        state_q,     state_d;
   logic [CODE_W-1:0]  entry_q,     entry_d;   // also the staging register in PROGRAM
   logic [CODE_W-1:0]  code_q,      code_d;
   logic [2:0]         digit_cnt_q, digit_cnt_d;
   logic [1:0]         fail_cnt_q,  fail_cnt_d;
   logic               error_q,     error_d;
   logic [TICK_W-1:0]  timer_q,     timer_d;
   logic               unlocked_q,  unlocked_d;
   logic               lockout_q,   lockout_d;

   logic [CODE_W-1:0]  key_shift;
   logic [2:0]         digit_inc;
   logic               last_digit;
   logic [1:0]         fail_inc;
   logic               key_taken;
   logic               unlock_exp, lockout_exp, entry_exp;

   // Expiry fires on the tick that brings the count to the limit.
   assign unlock_exp  = tick && (timer_q == TICK_W'(UNLOCK_TICKS - 1));
   assign lockout_exp = tick && (timer_q == TICK_W'(LOCKOUT_TICKS - 1));
   assign entry_exp   = tick && (timer_q == TICK_W'(ENTRY_TIMEOUT - 1));

   assign key_shift  = {entry_q[CODE_W-DIGIT_W-1:0], key_idx};
   assign digit_inc  = digit_cnt_q + 3'd1;
   assign last_digit = (digit_inc == 3'(CODE_LEN));
   assign fail_inc   = (fail_cnt_q == 2'(MAX_FAILS)) ? fail_cnt_q : fail_cnt_q + 2'd1;

   // State register
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and datapath
   always_comb begin
      state_d     = state_q;
      entry_d     = entry_q;
      code_d      = code_q;
      digit_cnt_d = digit_cnt_q;
      fail_cnt_d  = fail_cnt_q;
      error_d     = error_q;
      key_taken   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (key_vld) begin
               entry_d     = CODE_W'(key_idx);
               digit_cnt_d = 3'd1;
               error_d     = 1'b0;
               state_d     = ST_ENTRY;
            end
         end
         ST_ENTRY: begin
            // A key event beats a timeout tick in the same cycle.
            if (key_vld) begin
               key_taken   = 1'b1;
               entry_d     = key_shift;
               digit_cnt_d = digit_inc;
               if (last_digit) begin
                  state_d = ST_CHECK;
               end
            end else if (entry_exp) begin
               digit_cnt_d = '0;
               state_d     = ST_IDLE;
            end
         end
         ST_CHECK: begin
            digit_cnt_d = '0;
            if (entry_q == code_q) begin
               fail_cnt_d = '0;
               state_d    = ST_OPEN;
            end else begin
               fail_cnt_d = fail_inc;
               error_d    = 1'b1;
               state_d    = (fail_inc == 2'(MAX_FAILS)) ? ST_LOCKOUT : ST_IDLE;
            end
         end
         ST_OPEN: begin
            if (set_rise) begin
               digit_cnt_d = '0;
               state_d     = ST_PROGRAM;
            end else if (unlock_exp) begin
               state_d = ST_IDLE;
            end
         end
         ST_PROGRAM: begin
            if (key_vld) begin
               key_taken = 1'b1;
               if (last_digit) begin
                  code_d      = key_shift;
                  digit_cnt_d = '0;
                  state_d     = ST_IDLE;
               end else begin
                  entry_d     = key_shift;
                  digit_cnt_d = digit_inc;
               end
            end else if (entry_exp) begin
               digit_cnt_d = '0;
               state_d     = ST_IDLE;
            end
         end
         ST_LOCKOUT: begin
            if (lockout_exp) begin
               fail_cnt_d = '0;
               error_d    = 1'b0;
               state_d    = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      // Timers restart on every state entry and on every accepted digit.
      if ((state_d != state_q) || key_taken || (state_q == ST_IDLE)) begin
         timer_d = '0;
      end else if (tick) begin
         timer_d = timer_q + TICK_W'(1);
      end else begin
         timer_d = timer_q;
      end
   end

   // Outputs, decoded from the next state so the flops line up with state_q
   always_comb begin
      unlocked_d = (state_d == ST_OPEN) || (state_d == ST_PROGRAM);
      lockout_d  = (state_d == ST_LOCKOUT);
   end

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         entry_q     <= '0;
         code_q      <= DEFAULT_CODE;
         digit_cnt_q <= '0;
         fail_cnt_q  <= '0;
         error_q     <= 1'b0;
         timer_q     <= '0;
         unlocked_q  <= 1'b0;
         lockout_q   <= 1'b0;
      end else begin
         entry_q     <= entry_d;
         code_q      <= code_d;
         digit_cnt_q <= digit_cnt_d;
         fail_cnt_q  <= fail_cnt_d;
         error_q     <= error_d;
         timer_q     <= timer_d;
         unlocked_q  <= unlocked_d;
         lockout_q   <= lockout_d;
      end
   end

   assign unlocked  = unlocked_q;
   assign lockout   = lockout_q;
   assign error     = error_q;
   assign digit_cnt = digit_cnt_q;
   assign fail_cnt  = fail_cnt_q;

endmodule

// File: tb/tb_lock_controller.sv
// Scoreboard bench for lock_controller: every change of the output vector is matched against
// the next expected snapshot, with optional bounds on the cycles since the previous change.
// Ports: none (top-level bench).
module tb_lock_controller;

   localparam int P       = 16;            // divided_clk period in clk_in cycles
   localparam int UNL_MIN = 24 * P + 1;
   localparam int UNL_MAX = 25 * P;
   localparam int LCK_MIN = 99 * P + 1;
   localparam int LCK_MAX = 100 * P;
   localparam int TO_MIN  = 19 * P + 1;
   localparam int TO_MAX  = 20 * P;

   logic       clk_in      = 1'b0;
   logic       rst         = 1'b0;
   logic       divided_clk = 1'b0;
   logic       set_code    = 1'b0;
   logic [3:0] btn         = 4'b0000;
   logic       unlocked, lockout, error;
   logic [2:0] digit_cnt;
   logic [1:0] fail_cnt;
   logic [7:0] outs;

   lock_controller dut (
      .clk_in      (clk_in),
      .rst         (rst),
      .divided_clk (divided_clk),
      .btn         (btn),
      .set_code    (set_code),
      .unlocked    (unlocked),
      .lockout     (lockout),
      .error       (error),
      .digit_cnt   (digit_cnt),
      .fail_cnt    (fail_cnt)
   );

   assign outs = {unlocked, lockout, error, digit_cnt, fail_cnt};

   always #5 clk_in = ~clk_in;

   initial begin
      forever begin
         repeat (P / 2) @(negedge clk_in);
         divided_clk = ~divided_clk;
      end
   end

   typedef struct {
      string      tag;
      logic [7:0] outs;
      int         gmin;
      int         gmax;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   cyc      = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   // Monitor: any change of the outputs must be the next expected snapshot.
   initial begin
      logic [7:0] prev_outs;
      int         last_cyc;
      exp_t       e;
      int         gap;
      prev_outs = '0;
      last_cyc  = 0;
      forever begin
         @(negedge clk_in);
         cyc++;
         if (outs !== prev_outs) begin
            gap = cyc - last_cyc;
            if (sb_q.size() == 0) begin
               check("unexpected_change", 32'(outs), 32'(prev_outs));
            end else begin
               e = sb_q.pop_front();
               check(e.tag, 32'(outs), 32'(e.outs));
               if (e.gmax != 0) begin
                  check({e.tag, "_gap_in_range"}, 32'(gap >= e.gmin && gap <= e.gmax), 32'd1);
                  if (!(gap >= e.gmin && gap <= e.gmax))
                     $display("  %s: gap %0d cycles, allowed %0d..%0d", e.tag, gap, e.gmin, e.gmax);
               end
            end
            prev_outs = outs;
            last_cyc  = cyc;
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk_in);
   endtask

   task automatic press(input int k);
      btn = 4'(1 << k);
      idle(4 * P);
      btn = 4'b0000;
      idle(4 * P);
   endtask

   task automatic enter(input int a, input int b, input int c, input int d);
      press(a); press(b); press(c); press(d);
   endtask

   task automatic exp_o(input string tag, input logic u, input logic l, input logic e,
                        input int d, input int f, input int gmin = 0, input int gmax = 0);
      exp_t x;
      x.tag  = tag;
      x.outs = {u, l, e, 3'(d), 2'(f)};
      x.gmin = gmin;
      x.gmax = gmax;
      sb_q.push_back(x);
   endtask

   // Four ENTRY digits from IDLE: the first key clears error, fail_cnt is carried.
   task automatic exp_digits(input string tag, input int f);
      for (int i = 1; i <= 4; i++) exp_o($sformatf("%s_d%0d", tag, i), 1'b0, 1'b0, 1'b0, i, f);
   endtask

   task automatic drain(input string tag, input int budget);
      int n = 0;
      while (sb_q.size() != 0 && n < budget) begin
         @(negedge clk_in);
         n++;
      end
      check({tag, "_drained"}, 32'(sb_q.size()), 32'd0);
      sb_q.delete();
   endtask

   // Full successful unlock including the timed close.
   task automatic unlock_seq(input string tag, input int a, input int b, input int c, input int d, input int f);
      exp_digits(tag, f);
      exp_o({tag, "_open"},  1'b1, 1'b0, 1'b0, 0, 0);
      exp_o({tag, "_close"}, 1'b0, 1'b0, 1'b0, 0, 0, UNL_MIN, UNL_MAX);
      enter(a, b, c, d);
      drain(tag, 800);
   endtask

   // Three wrong codes from fail_cnt 0, ending as lockout begins.
   task automatic lockout_seq(input string tag);
      exp_digits({tag, "1"}, 0);
      exp_o({tag, "1_chk"}, 1'b0, 1'b0, 1'b1, 0, 1);
      exp_digits({tag, "2"}, 1);
      exp_o({tag, "2_chk"}, 1'b0, 1'b0, 1'b1, 0, 2);
      exp_digits({tag, "3"}, 2);
      exp_o({tag, "3_chk"}, 1'b0, 1'b1, 1'b1, 0, 3);
      for (int i = 0; i < 3; i++) enter(3, 3, 3, 3);
   endtask

   task automatic pulse_reset(input string tag);
      exp_o({tag, "_cleared"}, 1'b0, 1'b0, 1'b0, 0, 0);
      @(negedge clk_in);
      #2 rst = 1'b1;
      set_code = 1'b0;
      btn      = 4'b0000;
      #1 check({tag, "_async"}, 32'(outs), 32'd0);
      idle(3);
      rst = 1'b0;
      drain(tag, 10);
   endtask

   initial begin
      #1 rst = 1'b1;
      idle(4);
      check("reset_outs", 32'(outs), 32'd0);
      rst = 1'b0;
      idle(2 * P);

      // Default code opens for exactly UNLOCK_TICKS ticks.
      unlock_seq("ok", 0, 1, 2, 3, 0);

      // One failure, then a partial entry that times out without touching fail_cnt.
      exp_digits("bad", 0);
      exp_o("bad_chk", 1'b0, 1'b0, 1'b1, 0, 1);
      enter(3, 3, 3, 3);
      drain("bad", 100);
      exp_o("to_d1", 1'b0, 1'b0, 1'b0, 1, 1);
      exp_o("to_d2", 1'b0, 1'b0, 1'b0, 2, 1);
      exp_o("to_expire", 1'b0, 1'b0, 1'b0, 0, 1, TO_MIN, TO_MAX);
      press(0);
      press(1);
      drain("to", 600);
      unlock_seq("to_ok", 0, 1, 2, 3, 1);

      // Lockout; keys pressed during lockout must not change anything.
      lockout_seq("lk");
      exp_o("lk_expire", 1'b0, 1'b0, 1'b0, 0, 0, LCK_MIN, LCK_MAX);
      press(0);
      press(2);
      drain("lk", 2000);

      // Bouncing key gives one event; a chord gives none; entry then times out.
      exp_o("bn_d1", 1'b0, 1'b0, 1'b0, 1, 0);
      exp_o("bn_expire", 1'b0, 1'b0, 1'b0, 0, 0, TO_MIN, TO_MAX);
      for (int i = 0; i < P; i++) begin
         btn[2] = ~btn[2];
         idle(1);
      end
      btn = 4'b0100;
      idle(4 * P);
      btn = 4'b0000;
      idle(4 * P);
      btn = 4'b0110;
      idle(4 * P);
      btn = 4'b0000;
      idle(4 * P);
      drain("bn", 600);

      // Reprogram to 2,2,1,0 while open.
      exp_digits("rp", 0);
      exp_o("rp_open", 1'b1, 1'b0, 1'b0, 0, 0);
      enter(0, 1, 2, 3);
      drain("rp", 200);
      set_code = 1'b1;
      idle(4 * P);
      exp_o("pg_d1", 1'b1, 1'b0, 1'b0, 1, 0);
      exp_o("pg_d2", 1'b1, 1'b0, 1'b0, 2, 0);
      exp_o("pg_d3", 1'b1, 1'b0, 1'b0, 3, 0);
      exp_o("pg_commit", 1'b0, 1'b0, 1'b0, 0, 0);
      enter(2, 2, 1, 0);
      drain("pg", 200);
      set_code = 1'b0;
      idle(4 * P);
      exp_digits("old", 0);
      exp_o("old_chk", 1'b0, 1'b0, 1'b1, 0, 1);
      enter(0, 1, 2, 3);
      drain("old", 100);
      unlock_seq("new", 2, 2, 1, 0, 1);

      // Reset in the middle of PROGRAM restores the default code.
      exp_digits("rp2", 0);
      exp_o("rp2_open", 1'b1, 1'b0, 1'b0, 0, 0);
      enter(2, 2, 1, 0);
      drain("rp2", 200);
      set_code = 1'b1;
      idle(4 * P);
      exp_o("pg2_d1", 1'b1, 1'b0, 1'b0, 1, 0);
      exp_o("pg2_d2", 1'b1, 1'b0, 1'b0, 2, 0);
      press(1);
      press(1);
      drain("pg2", 100);
      pulse_reset("rst_prog");
      idle(4 * P);
      unlock_seq("dflt", 0, 1, 2, 3, 0);

      // Reset in the middle of lockout.
      lockout_seq("lkb");
      drain("lkb", 200);
      idle(20 * P);
      pulse_reset("rst_lock");
      idle(4 * P);
      unlock_seq("post", 0, 1, 2, 3, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
